uart_receiver: RTL

Serial-to-parallel UART receiver: the receive-side counterpart of the team's UART transmitter. It shares the same 16x oversampling tick (`s_tick`) and frame format: 1 start bit, DBIT data bits LSB first, and a stop period. It recovers each frame on the `rx` line, rejects start-bit glitches, flags framing errors, and presents each received byte with a one-cycle done pulse. It sits between the external `rx` pin and the PS/2-to-UART host logic.

---
 rtl/uart_receiver_if.sv | 12 +
 rtl/uart_receiver.sv | 116 +++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// Receiver-side bundle: the oversampling strobe and serial line going in,
// and the recovered byte, its status and the completion pulse coming out.
interface uart_receiver_if;
  logic       s_tick;
  logic       rx;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;

  modport master (output s_tick, rx, input rx_done_tick, dout, frame_err);
  modport slave  (input s_tick, rx, output rx_done_tick, dout, frame_err);
endinterface

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: start-glitch rejection, DBIT data bits LSB
// first, configurable stop period, framing-error flag and one-cycle done pulse.
module uart_receiver #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int SW    = $clog2(SB_TICK);
  localparam int SHIFT = 8 - DBIT;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_ZERO = SW'(0);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_r;
  logic [SW-1:0] s_r;
  logic [2:0]    n_r;
  logic [7:0]    b_r;
  logic [7:0]    dout_r;
  logic          frame_err_r;
  logic          done_r;
  logic [1:0]    sync_r;
  logic          rx_s;

  assign rx_s             = sync_r[1];
  assign bus.dout         = dout_r;
  assign bus.frame_err    = frame_err_r;
  assign bus.rx_done_tick = done_r;

  // Two-flop synchronizer for the asynchronous rx pin; idles at the line's mark level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], bus.rx};
    end
  end

  // Frame FSM with registered byte, status and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      s_r         <= S_ZERO;
      n_r         <= 3'd0;
      b_r         <= 8'd0;
      dout_r      <= 8'd0;
      frame_err_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            s_r     <= S_ZERO;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s_r == S_MID) begin
              // Line back high at mid-start means a glitch, not a frame.
              if (!rx_s) begin
                state_r <= DATA;
                s_r     <= S_ZERO;
                n_r     <= 3'd0;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              s_r <= s_r + S_ONE;
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s_r == S_LAST) begin
              s_r <= S_ZERO;
              b_r <= {rx_s, b_r[7:1]};
              if (n_r == N_LAST) begin
                state_r <= STOP;
              end else begin
                n_r <= n_r + 3'd1;
              end
            end else begin
              s_r <= s_r + S_ONE;
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if (s_r == S_STOP) begin
              state_r     <= IDLE;
              dout_r      <= b_r >> SHIFT;
              frame_err_r <= ~rx_s;
              done_r      <= 1'b1;
            end else begin
              s_r <= s_r + S_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
